// File: rtl/frame_dump_controller_pkg.sv
// Shared definitions for the frame capture/dump path: FSM encoding and default sizes.
package frame_dump_controller_pkg;

  localparam int DEF_ADDR_W    = 9;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_WORDS = 512;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURE   = 2'd1,
    ST_DUMP_ADDR = 2'd2,
    ST_DUMP_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/frame_dump_controller.sv
// Captures one received frame into an external RAM, then replays it word by word
// over a valid/ready stream. Frames arriving while a dump is in progress are dropped.
module frame_dump_controller
  import frame_dump_controller_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic              wr_word_valid,
  input  logic [DATA_W-1:0] wr_word,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_ena,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] dump_word,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   frame_len,
  output logic              overflow,
  output logic              frame_done,
  output logic [7:0]        drop_count
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  state_t              state_reg;
  logic [ADDR_W:0]     wr_ptr_reg;
  logic [ADDR_W:0]     rd_ptr_reg;
  logic [ADDR_W:0]     frame_len_reg;
  logic [DATA_W-1:0]   dump_word_reg;
  logic                dump_valid_reg;
  logic                overflow_reg;
  logic                frame_done_reg;
  logic [7:0]          drop_count_reg;
  logic                rx_dv_prev_reg;

  logic                wr_fire;
  logic                rx_rise;
  logic                in_dump;
  logic [ADDR_W:0]     rd_ptr_inc;

  assign wr_fire    = (state_reg == ST_CAPTURE) && wr_word_valid && (wr_ptr_reg < MAX_CNT);
  assign rx_rise    = rx_dv && !rx_dv_prev_reg;
  assign in_dump    = (state_reg == ST_DUMP_ADDR) || (state_reg == ST_DUMP_HOLD);
  assign rd_ptr_inc = rd_ptr_reg + ONE;

  // The write port is combinational so a word lands in RAM in the cycle it is offered.
  always_comb begin
    ram_addr = '0;
    case (state_reg)
      ST_CAPTURE:   ram_addr = wr_ptr_reg[ADDR_W-1:0];
      ST_DUMP_ADDR,
      ST_DUMP_HOLD: ram_addr = rd_ptr_reg[ADDR_W-1:0];
      default:      ram_addr = '0;
    endcase
  end

  assign ram_wr_ena  = wr_fire;
  assign ram_wr_data = wr_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      frame_len_reg  <= '0;
      dump_word_reg  <= '0;
      dump_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      drop_count_reg <= '0;
      // Treat rx_dv as already high so a capture needs a genuine low-to-high edge.
      rx_dv_prev_reg <= 1'b1;
    end else begin
      rx_dv_prev_reg <= rx_dv;
      frame_done_reg <= 1'b0;

      if (in_dump && rx_rise && (drop_count_reg != 8'hFF))
        drop_count_reg <= drop_count_reg + 8'd1;

      case (state_reg)
        ST_IDLE: begin
          if (rx_rise) begin
            state_reg    <= ST_CAPTURE;
            wr_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (wr_fire)
            wr_ptr_reg <= wr_ptr_reg + ONE;
          if (wr_word_valid && (wr_ptr_reg == MAX_CNT))
            overflow_reg <= 1'b1;
          if (!rx_dv) begin
            frame_len_reg <= wr_ptr_reg + {{ADDR_W{1'b0}}, wr_fire};
            rd_ptr_reg    <= '0;
            if ((wr_ptr_reg == '0) && !wr_fire)
              state_reg <= ST_IDLE;
            else
              state_reg <= ST_DUMP_ADDR;
          end
        end
        ST_DUMP_ADDR: begin
          state_reg <= ST_DUMP_HOLD;
        end
        ST_DUMP_HOLD: begin
          // First HOLD cycle latches the RAM output; later cycles wait for the handshake.
          if (!dump_valid_reg) begin
            dump_word_reg  <= ram_rd_data;
            dump_valid_reg <= 1'b1;
          end else if (dump_ready) begin
            dump_valid_reg <= 1'b0;
            rd_ptr_reg     <= rd_ptr_inc;
            if (rd_ptr_inc == frame_len_reg) begin
              frame_done_reg <= 1'b1;
              state_reg      <= ST_IDLE;
            end else begin
              state_reg <= ST_DUMP_ADDR;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign state      = state_reg;
  assign frame_len  = frame_len_reg;
  assign dump_word  = dump_word_reg;
  assign dump_valid = dump_valid_reg;
  assign overflow   = overflow_reg;
  assign frame_done = frame_done_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_frame_dump_controller.sv
// Scoreboard bench: two controllers (deep and 4-word capacity) share the stimulus;
// expected RAM writes and dump words are queued as frames are driven.
`timescale 1ns/1ps
module tb_frame_dump_controller;
  import frame_dump_controller_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;
  localparam int NI = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_dv;
  logic          wr_word_valid;
  logic [DW-1:0] wr_word;
  logic          dump_ready;

  logic [AW-1:0] ram_addr    [NI];
  logic          ram_wr_ena  [NI];
  logic [DW-1:0] ram_wr_data [NI];
  logic [DW-1:0] ram_rd_data [NI];
  logic [DW-1:0] dump_word   [NI];
  logic          dump_valid  [NI];
  logic [1:0]    state       [NI];
  logic [AW:0]   frame_len   [NI];
  logic          overflow    [NI];
  logic          frame_done  [NI];
  logic [7:0]    drop_count  [NI];

  logic [AW+DW-1:0] wr_q   [NI][$];
  logic [DW-1:0]    dump_q [NI][$];

  int done_cnt [NI];
  int dump_cnt [NI];
  int done_base[NI];
  int dump_base[NI];
  int exp_drop [NI];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic int mw(input int k);
    return (k == 0) ? 512 : 4;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [DW-1:0] mem [2**AW];

    frame_dump_controller #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_WORDS((gi == 0) ? 512 : 4)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_dv        (rx_dv),
      .wr_word_valid(wr_word_valid),
      .wr_word      (wr_word),
      .ram_addr     (ram_addr[gi]),
      .ram_wr_ena   (ram_wr_ena[gi]),
      .ram_wr_data  (ram_wr_data[gi]),
      .ram_rd_data  (ram_rd_data[gi]),
      .dump_word    (dump_word[gi]),
      .dump_valid   (dump_valid[gi]),
      .dump_ready   (dump_ready),
      .state        (state[gi]),
      .frame_len    (frame_len[gi]),
      .overflow     (overflow[gi]),
      .frame_done   (frame_done[gi]),
      .drop_count   (drop_count[gi])
    );

    // Simple synchronous RAM with one cycle read latency.
    always @(posedge clk) begin
      if (ram_wr_ena[gi]) mem[ram_addr[gi]] <= ram_wr_data[gi];
      ram_rd_data[gi] <= mem[ram_addr[gi]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Outputs are sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (ram_wr_ena[k] === 1'b1) begin
        check("wr_expected", (wr_q[k].size() > 0), 1'b1);
        if (wr_q[k].size() > 0)
          check("wr_addr_data", {ram_addr[k], ram_wr_data[k]}, wr_q[k].pop_front());
        $display("inst%0d write addr=%0d data=%08h", k, ram_addr[k], ram_wr_data[k]);
      end
      if ((dump_valid[k] === 1'b1) && dump_ready) begin
        check("dump_expected", (dump_q[k].size() > 0), 1'b1);
        if (dump_q[k].size() > 0)
          check("dump_word", dump_word[k], dump_q[k].pop_front());
        dump_cnt[k]++;
        $display("inst%0d dump word=%08h", k, dump_word[k]);
      end
      if (frame_done[k] === 1'b1) done_cnt[k]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot();
    for (int k = 0; k < NI; k++) begin
      done_base[k] = done_cnt[k];
      dump_base[k] = dump_cnt[k];
    end
  endtask

  task automatic send_frame(input int n, input logic [DW-1:0] base, input bit last_on_fall);
    logic [DW-1:0] d;
    rx_dv = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      d = base + DW'(i) * 32'h11;
      for (int k = 0; k < NI; k++) begin
        if (i < mw(k)) begin
          wr_q[k].push_back({AW'(i), d});
          dump_q[k].push_back(d);
        end
      end
      wr_word       = d;
      wr_word_valid = 1'b1;
      if (last_on_fall && (i == n - 1)) rx_dv = 1'b0;
      tick();
      wr_word_valid = 1'b0;
      if (!(last_on_fall && (i == n - 1))) tick();
    end
    rx_dv = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    tick();
    for (int c = 0; c < 400; c++) begin
      if ((state[0] == 2'd0) && (state[1] == 2'd0)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("idle_timeout", ok, 1'b1);
    tick();
    tick();
  endtask

  task automatic check_frame(input int n);
    int el;
    for (int k = 0; k < NI; k++) begin
      el = (n < mw(k)) ? n : mw(k);
      check("frame_len", frame_len[k], el);
      check("overflow", overflow[k], (n > mw(k)));
      check("done_pulses", done_cnt[k] - done_base[k], (el > 0) ? 1 : 0);
      check("wr_q_empty", wr_q[k].size(), 0);
      check("dump_q_empty", dump_q[k].size(), 0);
      check("drop_count", drop_count[k], exp_drop[k]);
      check("state_idle", state[k], 2'd0);
    end
  endtask

  initial begin
    logic [DW-1:0] held [NI];
    bit reached;

    rst = 1'b1;
    rx_dv = 1'b0;
    wr_word_valid = 1'b0;
    wr_word = '0;
    dump_ready = 1'b1;
    for (int k = 0; k < NI; k++) begin
      done_cnt[k] = 0;
      dump_cnt[k] = 0;
      exp_drop[k] = 0;
    end
    #3;
    for (int k = 0; k < NI; k++) begin
      check("rst_state", state[k], 2'd0);
      check("rst_dump_valid", dump_valid[k], 1'b0);
      check("rst_wr_ena", ram_wr_ena[k], 1'b0);
      check("rst_drop", drop_count[k], 8'd0);
      check("rst_frame_len", frame_len[k], 0);
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Basic 5-word frame 0x11..0x55
    snapshot();
    send_frame(5, 32'h11, 1'b0);
    wait_idle();
    check_frame(5);

    // Capacity overrun
    snapshot();
    send_frame(6, 32'h1000, 1'b0);
    wait_idle();
    check_frame(6);

    // Backpressure on the third dumped word
    snapshot();
    send_frame(6, 32'h2000, 1'b0);
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (dump_cnt[0] - dump_base[0] >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    check("stall_reach", reached, 1'b1);
    dump_ready = 1'b0;
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      held[k] = dump_word[k];
      check("stall_first", held[k], (dump_q[k].size() > 0) ? dump_q[k][0] : 32'hDEAD);
    end
    repeat (10) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        check("stall_valid", dump_valid[k], 1'b1);
        check("stall_hold", dump_word[k], held[k]);
        check("stall_addr", ram_addr[k], 2);
      end
    end
    dump_ready = 1'b1;
    wait_idle();
    check_frame(6);

    // Last word arrives in the same cycle rx_dv drops
    snapshot();
    send_frame(3, 32'h3000, 1'b1);
    wait_idle();
    check_frame(3);

    // Zero-word frame
    snapshot();
    rx_dv = 1'b1;
    repeat (3) tick();
    rx_dv = 1'b0;
    wait_idle();
    check_frame(0);

    // New frame pulse during a dump is dropped
    snapshot();
    send_frame(5, 32'h4000, 1'b0);
    tick();
    tick();
    rx_dv = 1'b1;
    tick();
    tick();
    rx_dv = 1'b0;
    for (int k = 0; k < NI; k++) exp_drop[k]++;
    wait_idle();
    check_frame(5);

    // Frame still active when the dump finishes is not captured
    snapshot();
    send_frame(5, 32'h5000, 1'b0);
    tick();
    tick();
    rx_dv = 1'b1;
    for (int k = 0; k < NI; k++) exp_drop[k]++;
    wait_idle();
    repeat (3) tick();
    rx_dv = 1'b0;
    repeat (3) tick();
    check_frame(5);

    // Asynchronous reset in the middle of a dump
    snapshot();
    send_frame(5, 32'h6000, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check("arst_state", state[k], 2'd0);
      check("arst_dump_valid", dump_valid[k], 1'b0);
      check("arst_addr", ram_addr[k], 0);
      check("arst_wr_ena", ram_wr_ena[k], 1'b0);
      check("arst_frame_len", frame_len[k], 0);
      check("arst_done", frame_done[k], 1'b0);
      wr_q[k].delete();
      dump_q[k].delete();
      exp_drop[k] = 0;
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < NI; k++)
      check("arst_no_done", done_cnt[k] - done_base[k], 0);

    // Capture resumes normally after reset
    snapshot();
    send_frame(2, 32'h7000, 1'b0);
    wait_idle();
    check_frame(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
